multicycle_controller: RTL and testbench

Multicycle control unit for the MIPS datapath. It replaces single-cycle opcode decoding with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake, so the core tolerates variable-latency memory. It drives every datapath mux/enable from one registered state and sits between the instruction register and the shared ALU/regfile/memory.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/multicycle_controller_branch_cond.sv | 22 ++
 rtl/multicycle_controller.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcode/funct constants, ALU operation codes and the decoded opcode class.
package mips_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_MDWAIT = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_XOR  = 6'b100110;
  localparam logic [5:0] ALU_SLT  = 6'b101010;
  localparam logic [5:0] ALU_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_RTYPE,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluation: maps a branch opcode and the ALU flags of
// the rs-rt subtraction to a take-branch bit.
module branch_cond
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            neg,
  output logic            take
);

  always_comb begin
    take = 1'b0;
    if (opcode == OP_W'(OP_BEQ))       take = zero;
    else if (opcode == OP_W'(OP_BNE))  take = ~zero;
    else if (opcode == OP_W'(OP_BLEZ)) take = zero | neg;
    else if (opcode == OP_W'(OP_BGTZ)) take = ~zero & ~neg;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM (fetch/decode/exec/mem/wb) with ready-handshake
// memory. Optional multiply/divide wait state is enabled by `define MULDIV_EN.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUSEL_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     OPCode_in,
  input  logic [FUNCT_W-1:0]  ALUSelect_in,
  input  logic                Zero_in,
  input  logic                Neg_in,
  input  logic                MemReady_in,
  input  logic                MulDivDone_in,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUSEL_W-1:0] ALUSelect_out,
  output logic                MulDivStart_out,
  output logic                Illegal_out
);

  state_t              state_q, state_d;
  op_class_t           cls;
  logic [ALUSEL_W-1:0] imm_alu;
  logic                is_muldiv;
  logic                take_branch;

  branch_cond #(.OP_W(OP_W)) u_branch_cond (
    .opcode (OPCode_in),
    .zero   (Zero_in),
    .neg    (Neg_in),
    .take   (take_branch)
  );

`ifndef MULDIV_EN
  logic unused_muldiv_done;
  assign unused_muldiv_done = MulDivDone_in;
`endif

  assign is_muldiv = (ALUSelect_in >= FUNCT_W'(FN_MULT)) &&
                     (ALUSelect_in <= FUNCT_W'(FN_DIVU));

  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_alu = ALUSEL_W'(ALU_ADD);
    case (OPCode_in)
      OP_W'(OP_RTYPE): cls = CLS_RTYPE;
      OP_W'(OP_J):     cls = CLS_JUMP;
      OP_W'(OP_BEQ), OP_W'(OP_BNE), OP_W'(OP_BLEZ), OP_W'(OP_BGTZ):
                       cls = CLS_BRANCH;
      OP_W'(OP_ADDI), OP_W'(OP_ADDIU):
                       cls = CLS_IALU;
      OP_W'(OP_SLTI):  begin cls = CLS_IALU; imm_alu = ALUSEL_W'(ALU_SLT);  end
      OP_W'(OP_SLTIU): begin cls = CLS_IALU; imm_alu = ALUSEL_W'(ALU_SLTU); end
      OP_W'(OP_ANDI):  begin cls = CLS_IALU; imm_alu = ALUSEL_W'(ALU_AND);  end
      OP_W'(OP_ORI):   begin cls = CLS_IALU; imm_alu = ALUSEL_W'(ALU_OR);   end
      OP_W'(OP_XORI):  begin cls = CLS_IALU; imm_alu = ALUSEL_W'(ALU_XOR);  end
      OP_W'(OP_LW):    cls = CLS_LOAD;
      OP_W'(OP_SW):    cls = CLS_STORE;
      default:         cls = CLS_ILLEGAL;
    endcase
  end

  // All controls are gated off while reset is high so an aborted
  // instruction cannot write the register file or memory.
  always_comb begin
    state_d         = state_q;
    PCWrite         = 1'b0;
    IRWrite         = 1'b0;
    IorD            = 1'b0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    MemtoReg        = 1'b0;
    RegDst          = 1'b0;
    RegWrite        = 1'b0;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    PCSource        = 2'b00;
    ALUSelect_out   = '0;
    MulDivStart_out = 1'b0;
    Illegal_out     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead       = 1'b1;
          ALUSrcB       = 2'b01;
          ALUSelect_out = ALUSEL_W'(ALU_ADD);
          if (MemReady_in) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: begin
          ALUSrcB       = 2'b11;
          ALUSelect_out = ALUSEL_W'(ALU_ADD);
          case (cls)
            CLS_JUMP: begin
              PCWrite  = 1'b1;
              PCSource = 2'b10;
              state_d  = ST_FETCH;
            end
            CLS_ILLEGAL: begin
              Illegal_out = 1'b1;
              state_d     = ST_FETCH;
            end
            default: state_d = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (cls)
            CLS_RTYPE: begin
              if (is_muldiv) begin
`ifdef MULDIV_EN
                MulDivStart_out = 1'b1;
                state_d         = ST_MDWAIT;
`else
                Illegal_out     = 1'b1;
                state_d         = ST_FETCH;
`endif
              end else begin
                ALUSrcA       = 1'b1;
                ALUSelect_out = (ALUSelect_in == '0) ? ALUSEL_W'(ALU_ADD)
                                                     : ALUSEL_W'(ALUSelect_in);
                state_d       = ST_WB;
              end
            end
            CLS_IALU: begin
              ALUSrcB       = 2'b10;
              ALUSelect_out = imm_alu;
              state_d       = ST_WB;
            end
            CLS_LOAD, CLS_STORE: begin
              ALUSrcB       = 2'b10;
              ALUSelect_out = ALUSEL_W'(ALU_ADD);
              state_d       = ST_MEM;
            end
            CLS_BRANCH: begin
              ALUSrcA       = 1'b1;
              ALUSelect_out = ALUSEL_W'(ALU_SUB);
              PCSource      = 2'b01;
              PCWrite       = take_branch;
              state_d       = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          IorD     = 1'b1;
          MemRead  = (cls == CLS_LOAD);
          MemWrite = (cls == CLS_STORE);
          if (MemReady_in) state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          RegWrite = 1'b1;
          RegDst   = (cls == CLS_RTYPE);
          MemtoReg = (cls == CLS_LOAD);
          state_d  = ST_FETCH;
        end
`ifdef MULDIV_EN
        ST_MDWAIT: begin
          if (MulDivDone_in) state_d = ST_FETCH;
        end
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; checks the packed control vector
// cycle by cycle against hand-written expectations. Honours `define MULDIV_EN.
module tb_multicycle_controller;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] AND_ = 6'b100100;
  localparam logic [5:0] OR_  = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110;
  localparam logic [5:0] SLT  = 6'b101010;
  localparam logic [5:0] SLTU = 6'b101011;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] fn;
  logic       zero, neg, rdy, done;

  logic       pcw, irw, iord, mr, mw, m2r, rd, rw, sa, mds, ill;
  logic [1:0] sb, pcs;
  logic [5:0] alu;
  logic [20:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] f_rdy, f_wait, dec, imm_add;

  multicycle_controller dut (
    .clk             (clk),
    .reset           (reset),
    .OPCode_in       (op),
    .ALUSelect_in    (fn),
    .Zero_in         (zero),
    .Neg_in          (neg),
    .MemReady_in     (rdy),
    .MulDivDone_in   (done),
    .PCWrite         (pcw),
    .IRWrite         (irw),
    .IorD            (iord),
    .MemRead         (mr),
    .MemWrite        (mw),
    .MemtoReg        (m2r),
    .RegDst          (rd),
    .RegWrite        (rw),
    .ALUSrcA         (sa),
    .ALUSrcB         (sb),
    .PCSource        (pcs),
    .ALUSelect_out   (alu),
    .MulDivStart_out (mds),
    .Illegal_out     (ill)
  );

  assign ctl = {pcw, irw, iord, mr, mw, m2r, rd, rw, sa, sb, pcs, alu, mds, ill};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [20:0] mk(input logic a_pcw, a_irw, a_iord, a_mr,
                                     a_mw, a_m2r, a_rd, a_rw, a_sa,
                                     input logic [1:0] a_sb, a_pcs,
                                     input logic [5:0] a_alu,
                                     input logic a_mds, a_ill);
    return {a_pcw, a_irw, a_iord, a_mr, a_mw, a_m2r, a_rd, a_rw, a_sa,
            a_sb, a_pcs, a_alu, a_mds, a_ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Sample one cycle's outputs away from the edge, then move to the next cycle.
  task automatic cyc(input string tag, input logic [20:0] exp);
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input string tag, input logic [5:0] opv, input logic z,
                        input logic n, input logic taken);
    op = opv; zero = z; neg = n;
    cyc({tag, "_fetch"}, f_rdy);
    cyc({tag, "_dec"}, dec);
    cyc({tag, "_exec"}, mk(taken, L, L, L, L, L, L, L, H, 2'b00, 2'b01, SUB, L, L));
  endtask

  task automatic ialu(input string tag, input logic [5:0] opv, input logic [5:0] exp_alu);
    op = opv;
    cyc({tag, "_fetch"}, f_rdy);
    cyc({tag, "_dec"}, dec);
    cyc({tag, "_exec"}, mk(L, L, L, L, L, L, L, L, L, 2'b10, 2'b00, exp_alu, L, L));
    cyc({tag, "_wb"}, mk(L, L, L, L, L, L, L, H, L, 2'b00, 2'b00, 6'b0, L, L));
  endtask

  task automatic rtype(input string tag, input logic [5:0] fnv, input logic [5:0] exp_alu);
    op = 6'b000000; fn = fnv;
    cyc({tag, "_fetch"}, f_rdy);
    cyc({tag, "_dec"}, dec);
    cyc({tag, "_exec"}, mk(L, L, L, L, L, L, L, L, H, 2'b00, 2'b00, exp_alu, L, L));
    cyc({tag, "_wb"}, mk(L, L, L, L, L, L, H, H, L, 2'b00, 2'b00, 6'b0, L, L));
  endtask

  initial begin
    f_rdy   = mk(H, H, L, H, L, L, L, L, L, 2'b01, 2'b00, ADD, L, L);
    f_wait  = mk(L, L, L, H, L, L, L, L, L, 2'b01, 2'b00, ADD, L, L);
    dec     = mk(L, L, L, L, L, L, L, L, L, 2'b11, 2'b00, ADD, L, L);
    imm_add = mk(L, L, L, L, L, L, L, L, L, 2'b10, 2'b00, ADD, L, L);

    reset = 1'b1; op = 6'b001000; fn = 6'b0;
    zero = 1'b0; neg = 1'b0; rdy = 1'b1; done = 1'b0;
    #1;
    repeat (3) cyc("reset_hold", 21'b0);
    reset = 1'b0;

    ialu("addi", 6'b001000, ADD);

    op = 6'b100011;
    cyc("lw_fetch", f_rdy);
    cyc("lw_dec", dec);
    cyc("lw_exec", imm_add);
    rdy = 1'b0;
    cyc("lw_mem_wait1", mk(L, L, H, H, L, L, L, L, L, 2'b00, 2'b00, 6'b0, L, L));
    cyc("lw_mem_wait2", mk(L, L, H, H, L, L, L, L, L, 2'b00, 2'b00, 6'b0, L, L));
    rdy = 1'b1;
    cyc("lw_mem_rdy", mk(L, L, H, H, L, L, L, L, L, 2'b00, 2'b00, 6'b0, L, L));
    cyc("lw_wb", mk(L, L, L, L, L, H, L, H, L, 2'b00, 2'b00, 6'b0, L, L));

    op = 6'b101011; rdy = 1'b0;
    cyc("sw_fetch_wait", f_wait);
    rdy = 1'b1;
    cyc("sw_fetch", f_rdy);
    cyc("sw_dec", dec);
    cyc("sw_exec", imm_add);
    cyc("sw_mem", mk(L, L, H, L, H, L, L, L, L, 2'b00, 2'b00, 6'b0, L, L));

    branch("bne_nz", 6'b000101, 1'b0, 1'b0, 1'b1);
    branch("bne_z", 6'b000101, 1'b1, 1'b0, 1'b0);
    branch("beq_z", 6'b000100, 1'b1, 1'b0, 1'b1);
    branch("blez_neg", 6'b000110, 1'b0, 1'b1, 1'b1);
    branch("bgtz_pos", 6'b000111, 1'b0, 1'b0, 1'b1);
    branch("bgtz_neg", 6'b000111, 1'b0, 1'b1, 1'b0);

    ialu("xori", 6'b001110, XOR_);
    rtype("r_fn0", 6'b000000, ADD);
    rtype("r_sub", 6'b100010, SUB);
    ialu("slti", 6'b001010, SLT);
    ialu("sltiu", 6'b001011, SLTU);
    ialu("andi", 6'b001100, AND_);
    ialu("ori", 6'b001101, OR_);

    op = 6'b000010;
    cyc("j_fetch", f_rdy);
    cyc("j_dec", mk(H, L, L, L, L, L, L, L, L, 2'b11, 2'b10, ADD, L, L));

    op = 6'b111111;
    cyc("ill_fetch", f_rdy);
    cyc("ill_dec", mk(L, L, L, L, L, L, L, L, L, 2'b11, 2'b00, ADD, L, H));
    op = 6'b001111;
    cyc("lui_fetch", f_rdy);
    cyc("lui_dec", mk(L, L, L, L, L, L, L, L, L, 2'b11, 2'b00, ADD, L, H));

    op = 6'b000000; fn = 6'b011000;
    cyc("mult_fetch", f_rdy);
    cyc("mult_dec", dec);
`ifdef MULDIV_EN
    done = 1'b1;
    cyc("mult_start", mk(L, L, L, L, L, L, L, L, L, 2'b00, 2'b00, 6'b0, H, L));
    done = 1'b0;
    repeat (4) cyc("mult_wait", 21'b0);
    done = 1'b1;
    cyc("mult_wait_last", 21'b0);
    done = 1'b0;
`else
    cyc("mult_illegal", mk(L, L, L, L, L, L, L, L, L, 2'b00, 2'b00, 6'b0, L, H));
`endif

    op = 6'b101011;
    cyc("rst_sw_fetch", f_rdy);
    cyc("rst_sw_dec", dec);
    cyc("rst_sw_exec", imm_add);
    reset = 1'b1;
    cyc("rst_sw_mem_abort", 21'b0);
    reset = 1'b0;
    op = 6'b100011;
    cyc("rst_lw_fetch", f_rdy);
    cyc("rst_lw_dec", dec);
    cyc("rst_lw_exec", imm_add);
    cyc("rst_lw_mem", mk(L, L, H, H, L, L, L, L, L, 2'b00, 2'b00, 6'b0, L, L));
    reset = 1'b1;
    cyc("rst_lw_wb_abort", 21'b0);
    reset = 1'b0;
    cyc("rst_after_fetch", f_rdy);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
